stream_rr_arbiter: RTL and testbench

//   Round-robin merge of NUM_IN first-word fall-through (FWFT) input streams into one FIFO write port.

---
 rtl/stream_rr_arbiter.sv | 130 +++++++++++++
 tb/tb_stream_rr_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_rr_arbiter.sv
// Round-robin merge of NUM_IN FWFT streams into one FIFO write port, tagging each word with its source index.
// Latency: 1 cycle from pop to out_write; each new grant costs one idle arbitration cycle.
// Backpressure: out_full_n low stalls the granted stream in place; the registered write needs downstream grace >= 1.
module stream_rr_arbiter #(
    parameter int NUM_IN     = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 8,
    parameter int IDX_WIDTH  = ($clog2(NUM_IN) > 0) ? $clog2(NUM_IN) : 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_IN-1:0]              in_empty_n,
    output logic [NUM_IN-1:0]              in_read,
    input  logic [NUM_IN*DATA_WIDTH-1:0]   in_dout,
    input  logic                           out_full_n,
    output logic                           out_write,
    output logic [IDX_WIDTH+DATA_WIDTH-1:0] out_din,
    output logic                           grant_valid,
    output logic [IDX_WIDTH-1:0]           grant_idx
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(MAX_BURST - 1);
    localparam logic [IDX_WIDTH-1:0] IDX_LAST = IDX_WIDTH'(NUM_IN - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t                state, state_nxt;
    logic [IDX_WIDTH-1:0]  rr_ptr, rr_ptr_nxt;
    logic [IDX_WIDTH-1:0]  grant, grant_nxt;
    logic [CNT_W-1:0]      burst_cnt, burst_cnt_nxt;

    logic                  sel_found;
    logic [IDX_WIDTH-1:0]  sel_idx;
    logic                  gnt_vld;
    logic [DATA_WIDTH-1:0] gnt_dat;
    logic                  pop;

    // Search order rr_ptr, rr_ptr+1, ... mod NUM_IN; first valid stream wins.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (!sel_found && in_empty_n[i] && (i == (int'(rr_ptr) + k) % NUM_IN)) begin
                    sel_found = 1'b1;
                    sel_idx   = IDX_WIDTH'(i);
                end
            end
        end
    end

    always_comb begin
        gnt_vld = 1'b0;
        gnt_dat = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (grant == IDX_WIDTH'(i)) begin
                gnt_vld = in_empty_n[i];
                gnt_dat = in_dout[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign pop         = (state == GRANT) && gnt_vld && out_full_n;
    assign grant_valid = (state == GRANT);
    assign grant_idx   = grant;

    always_comb begin
        in_read = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            in_read[i] = pop && (grant == IDX_WIDTH'(i));
        end
    end

    always_comb begin
        state_nxt     = state;
        rr_ptr_nxt    = rr_ptr;
        grant_nxt     = grant;
        burst_cnt_nxt = burst_cnt;
        case (state)
            IDLE: begin
                if (sel_found) begin
                    grant_nxt     = sel_idx;
                    burst_cnt_nxt = '0;
                    state_nxt     = GRANT;
                end
            end
            GRANT: begin
                // A stall (valid but full) falls through every branch and holds everything.
                if (!gnt_vld || (pop && burst_cnt == CNT_LAST)) begin
                    rr_ptr_nxt = (grant == IDX_LAST) ? '0 : grant + 1'b1;
                    state_nxt  = IDLE;
                end else if (pop) begin
                    burst_cnt_nxt = burst_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant     <= '0;
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            rr_ptr    <= rr_ptr_nxt;
            grant     <= grant_nxt;
            burst_cnt <= burst_cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_write <= 1'b0;
            out_din   <= '0;
        end else begin
            out_write <= pop;
            if (pop) begin
                out_din <= {grant, gnt_dat};
            end
        end
    end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Bench for stream_rr_arbiter: dut_a (4 streams, burst 8) and dut_b (3 streams, burst 1) run side by side
// against a behavioural arbiter model, a per-DUT output scoreboard and a small downstream FIFO.
module tb_stream_rr_arbiter;

    localparam int DS_DEPTH = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic [3:0]   en   [2];
    logic [127:0] dinp [2];
    logic         fn   [2];

    logic [3:0]  rd_a;
    logic [2:0]  rd_b;
    logic        ow_a, ow_b;
    logic [33:0] od_a, od_b;
    logic        gv_a, gv_b;
    logic [1:0]  gi_a, gi_b;

    stream_rr_arbiter #(.NUM_IN(4), .DATA_WIDTH(32), .MAX_BURST(8)) dut_a (
        .clk(clk), .reset(reset), .in_empty_n(en[0]), .in_read(rd_a), .in_dout(dinp[0]),
        .out_full_n(fn[0]), .out_write(ow_a), .out_din(od_a), .grant_valid(gv_a), .grant_idx(gi_a));

    stream_rr_arbiter #(.NUM_IN(3), .DATA_WIDTH(32), .MAX_BURST(1)) dut_b (
        .clk(clk), .reset(reset), .in_empty_n(en[1][2:0]), .in_read(rd_b), .in_dout(dinp[1][95:0]),
        .out_full_n(fn[1]), .out_write(ow_b), .out_din(od_b), .grant_valid(gv_b), .grant_idx(gi_b));

    int total, bad;
    int m_st [2], m_rr [2], m_g [2], m_cnt [2];
    logic        wr_exp [2];
    logic [33:0] exp_q [2][$];
    logic [33:0] ds_q  [2][$];
    logic [31:0] src_q [8][$];
    int          seq [8];
    int          wait_cnt [8];
    int          tx [2], rx [2];
    int          glog [2][$];
    logic        gv_prev [2];
    logic [3:0]  en_prev [2];
    logic        fn_force [2];
    logic        rst_req;
    bit          use_ds, arrivals;
    int          cyc_n, rel_cyc, first_wr;

    function automatic int ni(input int d);  return (d == 0) ? 4 : 3; endfunction
    function automatic int mb(input int d);  return (d == 0) ? 8 : 1; endfunction
    function automatic logic [3:0]  get_rd(input int d); return (d == 0) ? rd_a : {1'b0, rd_b}; endfunction
    function automatic logic        get_ow(input int d); return (d == 0) ? ow_a : ow_b; endfunction
    function automatic logic [33:0] get_od(input int d); return (d == 0) ? od_a : od_b; endfunction
    function automatic logic        get_gv(input int d); return (d == 0) ? gv_a : gv_b; endfunction
    function automatic logic [1:0]  get_gi(input int d); return (d == 0) ? gi_a : gi_b; endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push_word(input int d, input int i);
        int k;
        k = d * 4 + i;
        src_q[k].push_back({8'(d), 8'(i), 16'(seq[k])});
        seq[k]++;
        tx[d]++;
    endtask

    function automatic bit busy();
        bit b;
        b = 1'b0;
        for (int k = 0; k < 8; k++) if (src_q[k].size() > 0) b = 1'b1;
        for (int d = 0; d < 2; d++) if (m_st[d] == 1 || wr_exp[d]) b = 1'b1;
        return b;
    endfunction

    // One clock: check registered outputs, apply new inputs, then check combinational outputs and advance the model.
    task automatic cyc();
        logic [33:0] e;
        logic [31:0] w;
        logic [3:0]  r;
        int          g, k;
        bit          pop, found;
        @(negedge clk);
        cyc_n++;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("out_write[%0d]", d), 64'(get_ow(d)), 64'(wr_exp[d]));
            if (wr_exp[d] && exp_q[d].size() > 0) begin
                e = exp_q[d].pop_front();
                chk($sformatf("out_din[%0d]", d), 64'(get_od(d)), 64'(e));
                rx[d]++;
                if (use_ds) begin
                    chk($sformatf("ds_overflow[%0d]", d), 64'(ds_q[d].size() < DS_DEPTH), 64'(1));
                    ds_q[d].push_back(get_od(d));
                end
            end
            if (d == 0 && get_ow(0) && first_wr < 0) first_wr = cyc_n;
            if (get_gv(d) && !gv_prev[d]) begin
                g = int'(get_gi(d));
                glog[d].push_back(g);
                for (int i = 0; i < ni(d); i++) begin
                    if (i != g && en_prev[d][i]) begin
                        wait_cnt[d*4+i]++;
                        chk($sformatf("starve[%0d][%0d]", d, i), 64'(wait_cnt[d*4+i] <= ni(d) - 1), 64'(1));
                    end
                end
                wait_cnt[d*4+g] = 0;
            end
            gv_prev[d] = get_gv(d);
            if (use_ds && ds_q[d].size() > 0 && $urandom_range(1, 0) == 1) void'(ds_q[d].pop_front());
            if (arrivals) begin
                for (int i = 0; i < ni(d); i++)
                    if ($urandom_range(3, 0) == 0 && src_q[d*4+i].size() < 6) push_word(d, i);
            end
            en[d]   = '0;
            dinp[d] = '0;
            for (int i = 0; i < ni(d); i++) begin
                if (src_q[d*4+i].size() > 0) begin
                    en[d][i] = 1'b1;
                    dinp[d][i*32 +: 32] = src_q[d*4+i][0];
                end
            end
            fn[d] = use_ds ? (ds_q[d].size() < 2 && $urandom_range(3, 0) != 0) : fn_force[d];
            en_prev[d] = en[d];
        end
        reset = rst_req;
        #1;
        for (int d = 0; d < 2; d++) begin
            if (!reset) begin
                m_st[d] = 0; m_rr[d] = 0; m_g[d] = 0; m_cnt[d] = 0;
                wr_exp[d] = 1'b0;
                exp_q[d].delete();
                chk($sformatf("rst_in_read[%0d]", d), 64'(get_rd(d)), 64'(0));
                chk($sformatf("rst_grant_valid[%0d]", d), 64'(get_gv(d)), 64'(0));
                chk($sformatf("rst_out_din[%0d]", d), 64'(get_od(d)), 64'(0));
            end else begin
                pop = (m_st[d] == 1) && en[d][m_g[d]] && fn[d];
                r   = pop ? 4'(1 << m_g[d]) : 4'b0;
                chk($sformatf("in_read[%0d]", d), 64'(get_rd(d)), 64'(r));
                chk($sformatf("grant_valid[%0d]", d), 64'(get_gv(d)), 64'(m_st[d] == 1));
                if (m_st[d] == 1) chk($sformatf("grant_idx[%0d]", d), 64'(get_gi(d)), 64'(m_g[d]));
                if (pop) begin
                    k = d * 4 + m_g[d];
                    w = src_q[k].pop_front();
                    exp_q[d].push_back({2'(m_g[d]), w});
                end
                wr_exp[d] = pop;
                if (m_st[d] == 0) begin
                    found = 1'b0;
                    for (int j = 0; j < ni(d); j++) begin
                        g = (m_rr[d] + j) % ni(d);
                        if (!found && en[d][g]) begin
                            found = 1'b1;
                            m_g[d] = g;
                        end
                    end
                    if (found) begin
                        m_st[d]  = 1;
                        m_cnt[d] = 0;
                    end
                end else if (!en[d][m_g[d]] || (pop && m_cnt[d] == mb(d) - 1)) begin
                    m_rr[d] = (m_g[d] + 1) % ni(d);
                    m_st[d] = 0;
                end else if (pop) begin
                    m_cnt[d]++;
                end
            end
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (n < 3000 && busy()) begin
            cyc();
            n++;
        end
        chk("drain_done", 64'(busy()), 64'(0));
        repeat (2) cyc();
    endtask

    initial begin
        int base;
        int exp3 [4];
        int exp4 [2];
        total = 0; bad = 0;
        reset = 1'b0; rst_req = 1'b0;
        use_ds = 1'b0; arrivals = 1'b0;
        cyc_n = 0; rel_cyc = 0; first_wr = -1;
        for (int d = 0; d < 2; d++) begin
            en[d] = '0; dinp[d] = '0; fn[d] = 1'b1; fn_force[d] = 1'b1;
            m_st[d] = 0; m_rr[d] = 0; m_g[d] = 0; m_cnt[d] = 0;
            wr_exp[d] = 1'b0; tx[d] = 0; rx[d] = 0;
            gv_prev[d] = 1'b0; en_prev[d] = '0;
        end
        for (int k = 0; k < 8; k++) begin
            seq[k] = 0; wait_cnt[k] = 0;
        end

        // Reset held with every dut_a stream valid, then full-rate bursts 0,1,2,3,0,...
        for (int i = 0; i < 4; i++) for (int n = 0; n < 16; n++) push_word(0, i);
        repeat (3) cyc();
        rst_req = 1'b1;
        cyc();
        rel_cyc = cyc_n;
        drain();
        chk("first_write_latency", 64'(first_wr - rel_cyc), 64'(2));
        chk("burst_grant_count", 64'(glog[0].size()), 64'(8));
        for (int k = 0; k < 8 && k < glog[0].size(); k++)
            chk($sformatf("burst_order[%0d]", k), 64'(glog[0][k]), 64'(k % 4));
        chk("burst_words", 64'(rx[0]), 64'(64));

        // Stream 2 empties mid-burst; nothing granted without a request; rr_ptr ends at 3.
        glog[0].delete();
        base = rx[0];
        for (int n = 0; n < 3; n++) push_word(0, 2);
        drain();
        chk("short_burst_words", 64'(rx[0] - base), 64'(3));
        repeat (3) begin
            cyc();
            chk("idle_no_grant", 64'(gv_a), 64'(0));
        end
        for (int n = 0; n < 2; n++) push_word(0, 2);
        drain();
        push_word(0, 1);
        push_word(0, 3);
        drain();
        exp3 = '{2, 2, 3, 1};
        chk("rr_grant_count", 64'(glog[0].size()), 64'(4));
        for (int k = 0; k < 4 && k < glog[0].size(); k++)
            chk($sformatf("rr_order[%0d]", k), 64'(glog[0][k]), 64'(exp3[k]));

        // Downstream full for 5 cycles mid-burst.
        glog[0].delete();
        base = rx[0];
        for (int n = 0; n < 12; n++) push_word(0, 1);
        repeat (4) cyc();
        fn_force[0] = 1'b0;
        repeat (5) begin
            cyc();
            chk("stall_in_read", 64'(rd_a), 64'(0));
            chk("stall_grant_valid", 64'(gv_a), 64'(1));
            chk("stall_grant_idx", 64'(gi_a), 64'(1));
        end
        fn_force[0] = 1'b1;
        drain();
        exp4 = '{1, 1};
        chk("stall_words", 64'(rx[0] - base), 64'(12));
        chk("stall_grant_count", 64'(glog[0].size()), 64'(2));
        for (int k = 0; k < 2 && k < glog[0].size(); k++)
            chk($sformatf("stall_order[%0d]", k), 64'(glog[0][k]), 64'(exp4[k]));

        // dut_b: burst of 1 over 3 streams, pointer wraps 2 -> 0.
        for (int i = 0; i < 3; i++) for (int n = 0; n < 4; n++) push_word(1, i);
        drain();
        chk("wrr_grant_count", 64'(glog[1].size()), 64'(12));
        for (int k = 0; k < 12 && k < glog[1].size(); k++)
            chk($sformatf("wrr_order[%0d]", k), 64'(glog[1][k]), 64'(k % 3));
        chk("wrr_words", 64'(rx[1]), 64'(12));

        // Random traffic into a shallow downstream FIFO.
        use_ds = 1'b1;
        arrivals = 1'b1;
        repeat (10000) cyc();
        arrivals = 1'b0;
        drain();
        chk("rand_words_a", 64'(rx[0]), 64'(tx[0]));
        chk("rand_words_b", 64'(rx[1]), 64'(tx[1]));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
